sim_sequencer: RTL and testbench
================================

SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 SHALL have parameter N_CFG, default 4: number of selectable start configurations, 2..16.
REQ-002 SHALL have parameter PERIOD_CNT, default 3072000: clk cycles between automatic generations, >=2.
REQ-003 SHALL have parameter GEN_W, default 16: generation counter width.
REQ-004 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port i_cmd_toggle_pause  in  1: one-cycle pulse toggling run/pause.
REQ-007 SHALL have port i_cmd_step  in  1: one-cycle pulse requesting a single generation while paused.
REQ-008 SHALL have port i_cmd_load_cfg  in  N_CFG: one-hot-or-zero pulses; bit k requests load of config k.
REQ-009 SHALL have port i_nfi_busy  in  1: next-generation engine busy.
REQ-010 SHALL have port i_fcl_busy  in  1: config loader busy.
REQ-011 SHALL have port o_nfi_go  out  1: one-cycle start pulse to the generation engine.
REQ-012 SHALL have port o_fcl_go  out  1: one-cycle start pulse to the config loader.
REQ-013 SHALL have port o_fcl_cfg_sel  out  $clog2(N_CFG): config index, stable from o_fcl_go until load done.
REQ-014 SHALL have port o_rd_field  out  1: ping-pong field currently read/displayed; write field is its inverse.
REQ-015 SHALL have port o_running  out  1: 1 = auto-run, 0 = paused.
REQ-016 SHALL have port o_gen_cnt  out  GEN_W: generations since last load.

Function
REQ-017 SHALL implement states IDLE, WAIT_PERIOD, SIM_START, SIM_WAIT, LOAD_START, LOAD_WAIT.
REQ-018 SHALL, in IDLE with o_running=1, go to WAIT_PERIOD, count PERIOD_CNT cycles, then go to SIM_START.
REQ-019 SHALL, on entering SIM_START, assert o_nfi_go for exactly one cycle, hold in SIM_START until i_nfi_busy=1, then go to SIM_WAIT.
REQ-020 SHALL, in SIM_WAIT, on i_nfi_busy=0 invert o_rd_field, increment o_gen_cnt, and return to IDLE the same cycle.
REQ-021 SHALL, on i_cmd_step in IDLE with o_running=0, go to SIM_START; i_cmd_step is ignored in all other cases.
REQ-022 SHALL toggle o_running on i_cmd_toggle_pause in any state; a toggle during SIM_* or LOAD_* leaves the in-flight operation to complete.
REQ-023 SHALL, on pause in WAIT_PERIOD, return to IDLE and clear the period counter.
REQ-024 SHALL latch a load request into a pending register; multiple set bits or further requests overwrite it with the lowest set index.
REQ-025 SHALL serve a pending load only from IDLE or WAIT_PERIOD: LOAD_START (o_fcl_go one cycle, o_fcl_cfg_sel = index), wait for i_fcl_busy=1, then LOAD_WAIT.
REQ-026 SHALL, on i_fcl_busy=0 in LOAD_WAIT, invert o_rd_field, clear o_gen_cnt, clear pending, set o_running=0, and go to IDLE.
REQ-027 SHALL give a pending load priority over period expiry and step in the same cycle.
REQ-028 SHALL keep o_fcl_cfg_sel constant outside LOAD_*.

Reset
REQ-029 SHALL, on rst=1, force: state IDLE, o_nfi_go=0, o_fcl_go=0, o_fcl_cfg_sel=0, o_rd_field=0, o_running=0, o_gen_cnt=0, pending cleared, period counter 0.
REQ-030 SHALL abandon any in-flight handshake on reset; the engines are reset by the same rst.

Configuration
REQ-031 SHALL, with SIM_SEQ_GEN_SAT_EN defined, saturate o_gen_cnt at 2^GEN_W-1; without it, wrap to 0.

Structure
REQ-032 SHALL place the sim_seq_state_t enum and SIM_SEQ_* constants in package defs.
REQ-033 SHALL implement the period counter as sub-module period_timer (clear, enable, done pulse).

Verification
REQ-034 SHALL test: PERIOD_CNT=8, toggle pause, busy 3 cycles after go -> o_nfi_go every 8+handshake cycles; o_gen_cnt 0->1->2; o_rd_field alternates.
REQ-035 SHALL test: paused, i_cmd_step x1 -> exactly one o_nfi_go, o_gen_cnt=1, o_running stays 0.
REQ-036 SHALL test: i_cmd_load_cfg=4'b1010 during SIM_WAIT -> after busy drops, o_fcl_go with o_fcl_cfg_sel=1; after load o_gen_cnt=0, o_running=0.
REQ-037 SHALL test: pause toggled mid-SIM_WAIT -> generation completes, no further o_nfi_go.
REQ-038 SHALL test: GEN_W=2, 5 generations -> o_gen_cnt=3 with SIM_SEQ_GEN_SAT_EN, 1 without.
REQ-039 SHALL test: rst in LOAD_WAIT -> all outputs at REQ-029 values next cycle.

Source files
------------

// File: rtl/defs.sv
// Shared definitions for the simulation sequencer: FSM state encoding, request
// limits and the lowest-set-bit helper used to resolve load requests.
package defs;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_PERIOD = 3'd1,
    SIM_START   = 3'd2,
    SIM_WAIT    = 3'd3,
    LOAD_START  = 3'd4,
    LOAD_WAIT   = 3'd5
  } sim_seq_state_t;

  localparam int SIM_SEQ_MAX_CFG = 16;
  localparam int SIM_SEQ_IDX_W   = 4;

  // Lowest set index wins when several load requests are raised together.
  function automatic logic [SIM_SEQ_IDX_W-1:0] sim_seq_lowest_set(
    input logic [SIM_SEQ_MAX_CFG-1:0] req
  );
    logic [SIM_SEQ_IDX_W-1:0] idx;
    idx = 4'd0;
    for (int k = SIM_SEQ_MAX_CFG - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx = SIM_SEQ_IDX_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/period_timer.sv
// Auto-run interval counter: counts enabled cycles and raises done on the
// PERIOD_CNT-th one. Clear takes priority over enable.
module period_timer #(
  parameter int PERIOD_CNT = 3072000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int               CNT_W        = (PERIOD_CNT > 1) ? $clog2(PERIOD_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(PERIOD_CNT - 2);
  localparam logic [CNT_W-1:0] ONE_CNT      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT     = CNT_W'(0);

  logic [CNT_W-1:0] count_r;
  logic             done_r;

  // Done is flagged one cycle early so the registered pulse lands on the last counted cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r <= ZERO_CNT;
      done_r  <= 1'b0;
    end else if (enable) begin
      done_r  <= (count_r == PRE_LAST_CNT);
      count_r <= (count_r == LAST_CNT) ? ZERO_CNT : count_r + ONE_CNT;
    end else begin
      done_r  <= 1'b0;
    end
  end

  assign done = done_r;

endmodule

// File: rtl/sim_sequencer.sv
// Simulation sequencer: paces generation-engine runs, steps and config loads
// over a ping-pong field pair. Define SIM_SEQ_GEN_SAT_EN to saturate o_gen_cnt.
module sim_sequencer
  import defs::*;
#(
  parameter int N_CFG      = 4,
  parameter int PERIOD_CNT = 3072000,
  parameter int GEN_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_toggle_pause,
  input  logic                     i_cmd_step,
  input  logic [N_CFG-1:0]         i_cmd_load_cfg,
  input  logic                     i_nfi_busy,
  input  logic                     i_fcl_busy,
  output logic                     o_nfi_go,
  output logic                     o_fcl_go,
  output logic [$clog2(N_CFG)-1:0] o_fcl_cfg_sel,
  output logic                     o_rd_field,
  output logic                     o_running,
  output logic [GEN_W-1:0]         o_gen_cnt
);

  localparam int               CFG_W   = $clog2(N_CFG);
  localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

  sim_seq_state_t       state_r, state_next_s;
  logic                 pend_valid_r;
  logic [CFG_W-1:0]     pend_idx_r, cfg_sel_r, req_idx_s;
  logic                 nfi_go_r, fcl_go_r, rd_field_r, running_r;
  logic [GEN_W-1:0]     gen_cnt_r, gen_inc_s;
  logic                 run_next_s, req_any_s, sim_done_s, load_done_s;
  logic                 timer_clear_s, timer_en_s, timer_done_s;
  logic [SIM_SEQ_MAX_CFG-1:0] req_pad_s;

  period_timer #(.PERIOD_CNT(PERIOD_CNT)) u_period_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .done   (timer_done_s)
  );

  // Request decode and handshake completion strobes.
  always_comb begin
    req_pad_s   = SIM_SEQ_MAX_CFG'(i_cmd_load_cfg);
    req_any_s   = |i_cmd_load_cfg;
    req_idx_s   = CFG_W'(sim_seq_lowest_set(req_pad_s));
    run_next_s  = running_r ^ i_cmd_toggle_pause;
    sim_done_s  = (state_r == SIM_WAIT) && !i_nfi_busy;
    load_done_s = (state_r == LOAD_WAIT) && !i_fcl_busy;
  end

`ifdef SIM_SEQ_GEN_SAT_EN
  assign gen_inc_s = (&gen_cnt_r) ? gen_cnt_r : gen_cnt_r + GEN_ONE;
`else
  assign gen_inc_s = gen_cnt_r + GEN_ONE;
`endif

  // Next-state logic; a pending load outranks both period expiry and step.
  always_comb begin
    state_next_s  = state_r;
    timer_en_s    = 1'b0;
    timer_clear_s = 1'b1;
    case (state_r)
      IDLE: begin
        if (pend_valid_r)    state_next_s = LOAD_START;
        else if (running_r)  state_next_s = WAIT_PERIOD;
        else if (i_cmd_step) state_next_s = SIM_START;
        else                 state_next_s = IDLE;
      end
      WAIT_PERIOD: begin
        if (pend_valid_r) begin
          state_next_s = LOAD_START;
        end else if (!run_next_s) begin
          state_next_s = IDLE;
        end else if (timer_done_s) begin
          state_next_s = SIM_START;
        end else begin
          state_next_s  = WAIT_PERIOD;
          timer_en_s    = 1'b1;
          timer_clear_s = 1'b0;
        end
      end
      SIM_START: begin
        if (i_nfi_busy) state_next_s = SIM_WAIT;
        else            state_next_s = SIM_START;
      end
      SIM_WAIT: begin
        if (sim_done_s) state_next_s = IDLE;
        else            state_next_s = SIM_WAIT;
      end
      LOAD_START: begin
        if (i_fcl_busy) state_next_s = LOAD_WAIT;
        else            state_next_s = LOAD_START;
      end
      LOAD_WAIT: begin
        if (load_done_s) state_next_s = IDLE;
        else             state_next_s = LOAD_WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register and one-cycle start pulses raised on entry to a start state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      nfi_go_r <= 1'b0;
      fcl_go_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      nfi_go_r <= (state_next_s == SIM_START) && (state_r != SIM_START);
      fcl_go_r <= (state_next_s == LOAD_START) && (state_r != LOAD_START);
    end
  end

  // Pending load: a newer request overwrites, completion of a load clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_idx_r   <= CFG_W'(0);
    end else if (req_any_s) begin
      pend_valid_r <= 1'b1;
      pend_idx_r   <= req_idx_s;
    end else if (load_done_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Status registers: run flag, display field, generation count and config select.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_r  <= 1'b0;
      rd_field_r <= 1'b0;
      gen_cnt_r  <= GEN_W'(0);
      cfg_sel_r  <= CFG_W'(0);
    end else begin
      if (load_done_s)             running_r <= 1'b0;
      else if (i_cmd_toggle_pause) running_r <= ~running_r;
      else                         running_r <= running_r;

      if (sim_done_s || load_done_s) rd_field_r <= ~rd_field_r;
      else                           rd_field_r <= rd_field_r;

      if (load_done_s)     gen_cnt_r <= GEN_W'(0);
      else if (sim_done_s) gen_cnt_r <= gen_inc_s;
      else                 gen_cnt_r <= gen_cnt_r;

      if ((state_next_s == LOAD_START) && (state_r != LOAD_START)) cfg_sel_r <= pend_idx_r;
      else                                                         cfg_sel_r <= cfg_sel_r;
    end
  end

  assign o_nfi_go      = nfi_go_r;
  assign o_fcl_go      = fcl_go_r;
  assign o_fcl_cfg_sel = cfg_sel_r;
  assign o_rd_field    = rd_field_r;
  assign o_running     = running_r;
  assign o_gen_cnt     = gen_cnt_r;

endmodule

// File: tb/tb_sim_sequencer.sv
// Self-checking bench for sim_sequencer: the bench plays both engines and
// tracks expected run/field/count state with a small event-level model.
module tb_sim_sequencer;

  localparam int N_CFG      = 4;
  localparam int PERIOD_CNT = 8;
  localparam int GEN_W      = 2;
  localparam int GEN_MAX    = (1 << GEN_W) - 1;
`ifdef SIM_SEQ_GEN_SAT_EN
  localparam int GEN_AFTER5 = 3;
`else
  localparam int GEN_AFTER5 = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             toggle = 1'b0, step = 1'b0, nfi_busy = 1'b0, fcl_busy = 1'b0;
  logic [N_CFG-1:0] load_cfg = '0;
  logic             nfi_go, fcl_go, rd_field, running;
  logic [1:0]       cfg_sel;
  logic [GEN_W-1:0] gen_cnt;

  int checks = 0, passed = 0, cyc = 0, nfi_pulses = 0, fcl_pulses = 0;
  int exp_gen = 0;
  bit exp_rd = 1'b0, exp_run = 1'b0;

  sim_sequencer #(.N_CFG(N_CFG), .PERIOD_CNT(PERIOD_CNT), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .i_cmd_toggle_pause(toggle), .i_cmd_step(step),
    .i_cmd_load_cfg(load_cfg), .i_nfi_busy(nfi_busy), .i_fcl_busy(fcl_busy),
    .o_nfi_go(nfi_go), .o_fcl_go(fcl_go), .o_fcl_cfg_sel(cfg_sel),
    .o_rd_field(rd_field), .o_running(running), .o_gen_cnt(gen_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (nfi_go === 1'b1) nfi_pulses <= nfi_pulses + 1;
    if (fcl_go === 1'b1) fcl_pulses <= fcl_pulses + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_toggle();
    toggle = 1'b1; tick(); toggle = 1'b0;
    exp_run = ~exp_run;
  endtask

  task automatic model_gen_done();
    exp_rd = ~exp_rd;
`ifdef SIM_SEQ_GEN_SAT_EN
    if (exp_gen < GEN_MAX) exp_gen = exp_gen + 1;
`else
    exp_gen = (exp_gen + 1) % (GEN_MAX + 1);
`endif
  endtask

  task automatic model_load_done();
    exp_rd = ~exp_rd; exp_gen = 0; exp_run = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; toggle = 1'b0; step = 1'b0; nfi_busy = 1'b0; fcl_busy = 1'b0; load_cfg = '0;
    ticks(2);
    rst = 1'b0;
    exp_gen = 0; exp_rd = 1'b0; exp_run = 1'b0;
  endtask

  task automatic wait_nfi_go(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (nfi_go === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_fcl_go(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fcl_go === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
  endtask

  // Engine side of a handshake: idle d cycles, busy for h cycles, then release.
  task automatic serve_nfi(input int d, input int h);
    ticks(d); nfi_busy = 1'b1; ticks(h); nfi_busy = 1'b0; tick();
  endtask

  task automatic serve_fcl(input int d, input int h);
    ticks(d); fcl_busy = 1'b1; ticks(h); fcl_busy = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (nfi_go !== 1'b0) $display("FAIL reset_nfi_go: got %b want 0", nfi_go); else passed++;
    checks++; if (fcl_go !== 1'b0) $display("FAIL reset_fcl_go: got %b want 0", fcl_go); else passed++;
    checks++; if (cfg_sel !== 2'd0) $display("FAIL reset_cfg_sel: got %0d want 0", cfg_sel); else passed++;
    checks++; if (rd_field !== 1'b0) $display("FAIL reset_rd_field: got %b want 0", rd_field); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running); else passed++;
    checks++; if (gen_cnt !== 2'd0) $display("FAIL reset_gen_cnt: got %0d want 0", gen_cnt); else passed++;
  endtask

  task automatic test_autorun();
    bit seen;
    int prev_go = 0, h_prev = 0, h, p0;
    pulse_toggle();
    checks++; if (running !== exp_run) $display("FAIL run_on: got %b want %b", running, exp_run); else passed++;
    for (int g = 0; g < 5; g++) begin
      wait_nfi_go(40, seen);
      checks++; if (!seen) $display("FAIL auto_go_%0d: no o_nfi_go within 40 cycles", g); else passed++;
      if (g > 0) begin
        checks++;
        if (cyc - prev_go !== PERIOD_CNT + 2 + 3 + h_prev)
          $display("FAIL auto_interval_%0d: got %0d want %0d", g, cyc - prev_go, PERIOD_CNT + 5 + h_prev);
        else passed++;
      end
      prev_go = cyc;
      tick();
      checks++; if (nfi_go !== 1'b0) $display("FAIL auto_go_width_%0d: got %b want 0", g, nfi_go); else passed++;
      h = $urandom_range(1, 4);
      serve_nfi(2, h);
      h_prev = h;
      model_gen_done();
      checks++; if (gen_cnt !== GEN_W'(exp_gen)) $display("FAIL auto_gen_%0d: got %0d want %0d", g, gen_cnt, exp_gen); else passed++;
      checks++; if (rd_field !== exp_rd) $display("FAIL auto_rd_%0d: got %b want %b", g, rd_field, exp_rd); else passed++;
    end
    checks++; if (gen_cnt !== GEN_W'(GEN_AFTER5)) $display("FAIL gen_after5: got %0d want %0d", gen_cnt, GEN_AFTER5); else passed++;
    pulse_toggle();
    p0 = nfi_pulses;
    ticks(30);
    checks++; if (nfi_pulses !== p0) $display("FAIL auto_paused_go: got %0d pulses want %0d", nfi_pulses, p0); else passed++;
    checks++; if (running !== exp_run) $display("FAIL auto_paused_run: got %b want %b", running, exp_run); else passed++;
  endtask

  task automatic test_step();
    bit seen;
    int p0;
    do_reset();
    p0 = nfi_pulses;
    step = 1'b1; tick(); step = 1'b0;
    wait_nfi_go(10, seen);
    checks++; if (!seen) $display("FAIL step_go: no o_nfi_go within 10 cycles"); else passed++;
    serve_nfi($urandom_range(0, 3), $urandom_range(1, 4));
    model_gen_done();
    ticks(20);
    checks++; if (nfi_pulses !== p0 + 1) $display("FAIL step_pulses: got %0d want %0d", nfi_pulses - p0, 1); else passed++;
    checks++; if (gen_cnt !== GEN_W'(exp_gen)) $display("FAIL step_gen: got %0d want %0d", gen_cnt, exp_gen); else passed++;
    checks++; if (running !== exp_run) $display("FAIL step_running: got %b want %b", running, exp_run); else passed++;
  endtask

  task automatic test_load();
    bit seen;
    logic [N_CFG-1:0] vec;
    int exp_idx, p0, h;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      vec = (it == 0) ? 4'b1010 : N_CFG'($urandom_range(1, 15));
      exp_idx = 0;
      for (int k = 0; k < N_CFG; k++) if (vec[k]) begin exp_idx = k; break; end
      pulse_toggle();
      wait_nfi_go(40, seen);
      checks++; if (!seen) $display("FAIL load_gen_go_%0d: no o_nfi_go within 40 cycles", it); else passed++;
      h = $urandom_range(2, 4);
      ticks($urandom_range(0, 3));
      nfi_busy = 1'b1; tick();
      load_cfg = vec; tick(); load_cfg = '0;
      ticks(h - 2);
      nfi_busy = 1'b0; tick();
      model_gen_done();
      p0 = nfi_pulses;
      wait_fcl_go(10, seen);
      checks++; if (!seen) $display("FAIL load_fcl_go_%0d: no o_fcl_go within 10 cycles", it); else passed++;
      checks++; if (cfg_sel !== 2'(exp_idx)) $display("FAIL load_sel_%0d: got %0d want %0d", it, cfg_sel, exp_idx); else passed++;
      serve_fcl($urandom_range(0, 3), $urandom_range(1, 4));
      model_load_done();
      checks++; if (gen_cnt !== GEN_W'(exp_gen)) $display("FAIL load_gen_%0d: got %0d want %0d", it, gen_cnt, exp_gen); else passed++;
      checks++; if (running !== exp_run) $display("FAIL load_running_%0d: got %b want %b", it, running, exp_run); else passed++;
      checks++; if (rd_field !== exp_rd) $display("FAIL load_rd_%0d: got %b want %b", it, rd_field, exp_rd); else passed++;
      ticks(20);
      checks++; if (nfi_pulses !== p0) $display("FAIL load_no_gen_%0d: got %0d pulses want 0", it, nfi_pulses - p0); else passed++;
      checks++; if (cfg_sel !== 2'(exp_idx)) $display("FAIL load_sel_hold_%0d: got %0d want %0d", it, cfg_sel, exp_idx); else passed++;
    end
  endtask

  task automatic test_pause_mid();
    bit seen;
    int p0;
    do_reset();
    pulse_toggle();
    wait_nfi_go(40, seen);
    checks++; if (!seen) $display("FAIL mid_go: no o_nfi_go within 40 cycles"); else passed++;
    ticks($urandom_range(0, 2));
    nfi_busy = 1'b1; ticks(2);
    pulse_toggle();
    tick();
    nfi_busy = 1'b0; tick();
    model_gen_done();
    checks++; if (gen_cnt !== GEN_W'(exp_gen)) $display("FAIL mid_gen: got %0d want %0d", gen_cnt, exp_gen); else passed++;
    checks++; if (rd_field !== exp_rd) $display("FAIL mid_rd: got %b want %b", rd_field, exp_rd); else passed++;
    checks++; if (running !== exp_run) $display("FAIL mid_running: got %b want %b", running, exp_run); else passed++;
    p0 = nfi_pulses;
    ticks(30);
    checks++; if (nfi_pulses !== p0) $display("FAIL mid_no_go: got %0d pulses want 0", nfi_pulses - p0); else passed++;
  endtask

  task automatic test_reset_load_wait();
    bit seen;
    int p0;
    do_reset();
    step = 1'b1; tick(); step = 1'b0;
    wait_nfi_go(10, seen);
    serve_nfi(1, 2);
    model_gen_done();
    load_cfg = 4'b1000; tick(); load_cfg = '0;
    wait_fcl_go(10, seen);
    checks++; if (!seen) $display("FAIL rlw_fcl_go: no o_fcl_go within 10 cycles"); else passed++;
    tick(); fcl_busy = 1'b1; ticks(2);
    pulse_toggle();
    checks++; if (running !== 1'b1 || cfg_sel !== 2'd3 || gen_cnt !== 2'd1)
      $display("FAIL rlw_pre: got run=%b sel=%0d gen=%0d want run=1 sel=3 gen=1", running, cfg_sel, gen_cnt);
    else passed++;
    rst = 1'b1; tick();
    checks++; if ({nfi_go, fcl_go, cfg_sel, rd_field, running, gen_cnt} !== 8'd0)
      $display("FAIL rlw_reset: got nfi=%b fcl=%b sel=%0d rd=%b run=%b gen=%0d want all 0",
               nfi_go, fcl_go, cfg_sel, rd_field, running, gen_cnt);
    else passed++;
    rst = 1'b0; fcl_busy = 1'b0;
    p0 = nfi_pulses + fcl_pulses;
    ticks(20);
    checks++; if (nfi_pulses + fcl_pulses !== p0) $display("FAIL rlw_quiet: got %0d pulses want 0", nfi_pulses + fcl_pulses - p0); else passed++;
  endtask

  initial begin
    test_reset();
    test_autorun();
    test_step();
    test_load();
    test_pause_mid();
    test_reset_load_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
